inst_fetch_buffer: RTL
======================

# inst_fetch_buffer

Instruction prefetch stage between the core's fetch/decode front end and the instruction sram-like port of `cpu_axi_interface`. Issues sequential word-aligned read requests, tracks in-flight requests, queues returned instructions with their PCs in a small FIFO for decode, and handles branch/exception redirects by flushing the queue and discarding stale responses still in flight.

## Interface
- `DEPTH`, 4: FIFO entries and maximum requests in flight plus queued (power of 2, ≥2)
- `RESET_PC`, 32'h1c000000: first fetch address after reset

- `clk` in 1: clock
- `reset` in 1: reset; one clock; reset is asynchronous and active-high
- `redirect_valid` in 1: flush and restart fetch
- `redirect_pc` in 32: new fetch PC (word aligned)
- `inst_req` out 1: sram-like request
- `inst_wr` out 1: constant 0
- `inst_size` out 2: constant 2'b10
- `inst_addr` out 32: request address
- `inst_wstrb` out 4: constant 0
- `inst_wdata` out 32: constant 0
- `inst_addr_ok` in 1: request accepted
- `inst_data_ok` in 1: read data returned (in order)
- `inst_rdata` in 32: returned instruction
- `fb_valid` out 1: FIFO head valid
- `fb_pc` out 32: head PC
- `fb_inst` out 32: head instruction
- `fb_ready` in 1: decode consumes head

## Operation
- State: `fetch_pc` (next request addr), `resp_pc` (PC of next kept response), `outstanding` (accepted, no data_ok yet, incl. stale), `discard` (stale responses to drop), `hold` (request raised, not yet accepted), FIFO with `count`.
- Credit rule: new request raised only when `count + outstanding < DEPTH`, `hold`=0, `redirect_valid`=0.
- Hold rule: once `inst_req`=1 without `inst_addr_ok`, `inst_req` stays 1 and `inst_addr` stays unchanged until accepted, regardless of redirect or credits.
- Accept (`inst_req & inst_addr_ok`): `outstanding`+1; `fetch_pc`+4 if not stale; `hold` cleared.
- Response (`inst_data_ok`): `outstanding`−1; if `discard`>0: `discard`−1, drop; else push {`resp_pc`, `inst_rdata`}, `resp_pc`+4.
- Pop: `fb_valid & fb_ready`. Push and pop in same cycle allowed; FIFO cannot overflow by credit rule. Push into empty FIFO visible next cycle (no bypass).
- Redirect (highest priority): FIFO cleared (pop/push this cycle ignored), `fetch_pc`←`redirect_pc`, `resp_pc`←`redirect_pc`, `discard`← outstanding value after this cycle's accept/response (data_ok in redirect cycle is dropped). If a held request exists, it is flagged stale; on its acceptance `discard`+1 and `fetch_pc` not incremented.
- Back-to-back redirects: later one wins; `discard` recomputed each time.
- Counters: `outstanding`, `discard`, `count` each log2(DEPTH)+1 bits; addresses wrap modulo 2^32.

## Timing
- Reset values: `inst_req`=0, `inst_addr`=`RESET_PC`, `fb_valid`=0, `fb_pc`=0, `fb_inst`=0, all counters 0, `hold`=0, `fetch_pc`=`resp_pc`=`RESET_PC`.
- First cycle after reset release: `inst_req`=1, `inst_addr`=`RESET_PC`.
- Accept at cycle T → next request (addr+4) may be raised at T+1... combinationally at T+1 if credits allow; sustained one request per cycle with `inst_addr_ok`=1.
- `inst_data_ok` at T → `fb_valid`=1 at T+1.
- `redirect_valid` at T (no hold) → `inst_req` with `redirect_pc` at T+1; `fb_valid`=0 at T+1.
- Reset asserted mid-operation: all state cleared immediately; in-flight responses after release are not expected (interface reset together).

## Test plan
- Reset, `addr_ok`=1 always, `data_ok` one cycle after accept, `fb_ready`=1, rdata=addr^32'hFFFF0000 → requests 0x1c000000, 0x1c000004, …; `fb_pc`/`fb_inst` pairs match in order, one per cycle.
- `fb_ready`=0, DEPTH=4 → exactly 4 accepts, `inst_req` drops, `fb_valid`=1 with PC 0x1c000000; one pop → exactly one new request 0x1c000010.
- Two requests outstanding, redirect to 0x1c000100 → next two `data_ok` dropped; first `fb_pc`=0x1c000100.
- `addr_ok` held 0 with req 0x1c000008 pending, redirect to 0x1c000200 → `inst_addr` stays 0x1c000008 until accept; its response dropped; next request 0x1c000200.
- Redirect coincident with `data_ok`, push and pop → `fb_valid`=0 next cycle, that data never appears, `discard` excludes it.
- Assert `reset` with 3 outstanding and FIFO non-empty → outputs immediately return to reset values; after release, first request `RESET_PC`.

Source files
------------

// File: rtl/inst_fetch_buffer.sv
// Instruction prefetch buffer: issues sequential word reads on an sram-like
// port, counts requests in flight, queues returned instructions with their PCs
// for decode, and on a redirect flushes the queue and drops stale responses.
module inst_fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [3:0]  inst_wstrb,
  output logic [31:0] inst_wdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        fb_valid,
  output logic [31:0] fb_pc,
  output logic [31:0] fb_inst,
  input  logic        fb_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [31:0]   held_addr_q, held_addr_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          hold_q, hold_d;
  logic          stale_q, stale_d;

  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];

  logic [CW:0]   in_use;
  logic          credit_ok;
  logic          accept;
  logic          drop;
  logic          push;
  logic          pop;

  // Queued entries plus requests in flight never exceed DEPTH, so the FIFO
  // always has room for every response that is kept.
  assign in_use    = {1'b0, count_q} + {1'b0, outstanding_q};
  assign credit_ok = in_use < (CW + 1)'(DEPTH);

  // A held request stays raised with its address frozen until accepted; the
  // reset gate keeps the request low while reset is asserted.
  assign inst_req   = !reset && (hold_q || (credit_ok && !redirect_valid));
  assign inst_addr  = hold_q ? held_addr_q : fetch_pc_q;
  assign inst_wr    = 1'b0;
  assign inst_size  = 2'b10;
  assign inst_wstrb = 4'b0000;
  assign inst_wdata = 32'h0000_0000;

  assign accept = inst_req && inst_addr_ok;
  assign drop   = inst_data_ok && (discard_q != '0);
  assign push   = inst_data_ok && !drop && !redirect_valid;
  assign pop    = fb_valid && fb_ready && !redirect_valid;

  assign fb_valid = (count_q != '0);
  assign fb_pc    = pc_mem_q[rd_ptr_q];
  assign fb_inst  = inst_mem_q[rd_ptr_q];

  // Next-state: request handshake, response accounting, queue pointers, and
  // redirect which overrides everything else this cycle.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    held_addr_d   = held_addr_q;
    discard_d     = discard_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    hold_d        = hold_q;
    stale_d       = stale_q;
    outstanding_d = outstanding_q + CW'(accept) - CW'(inst_data_ok);

    if (accept) begin
      hold_d  = 1'b0;
      stale_d = 1'b0;
      if (hold_q && stale_q) begin
        // The stale request is now in flight; its response must be dropped.
        discard_d = discard_d + CW'(1);
      end else begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
    end else if (inst_req) begin
      hold_d      = 1'b1;
      held_addr_d = inst_addr;
    end

    if (drop) begin
      discard_d = discard_d - CW'(1);
    end

    if (push) begin
      wr_ptr_d  = wr_ptr_q + PW'(1);
      resp_pc_d = resp_pc_q + 32'd4;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);

    if (redirect_valid) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      // Everything still in flight after this cycle belongs to the old path.
      discard_d  = outstanding_d;
      if (hold_d) begin
        stale_d = 1'b1;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      held_addr_q   <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      hold_q        <= 1'b0;
      stale_q       <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      held_addr_q   <= held_addr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      hold_q        <= hold_d;
      stale_q       <= stale_d;
    end
  end

  // Queue storage; cleared on reset so the head outputs read zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]   <= resp_pc_q;
      inst_mem_q[wr_ptr_q] <= inst_rdata;
    end
  end

endmodule
